// File: rtl/bram_port_arbiter.sv
// ============================================================================
// bram_port_arbiter : two-requester round-robin arbiter for a simple-dual-port
//                     BRAM with a same-address read stall on collision
// Revision 1.0
// ============================================================================
`default_nettype none

module bram_port_arbiter #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 4,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [1:0]                 req_write,
   input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0][STRB_WIDTH-1:0] req_strb,
   input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]                 resp_valid,
   output logic [DATA_WIDTH-1:0]      resp_rdata,
   output logic [ADDR_WIDTH-1:0]      bram_raddr,
   output logic [ADDR_WIDTH-1:0]      bram_waddr,
   output logic [STRB_WIDTH-1:0]      bram_write_en,
   output logic [DATA_WIDTH-1:0]      bram_wdata,
   input  logic [DATA_WIDTH-1:0]      bram_rdata
);

   logic                  wr_prio;
   logic                  rd_prio;
   logic [ADDR_WIDTH-1:0] raddr_q;
   logic [1:0]            resp_valid_q;

   logic [1:0] wr_cand;
   logic [1:0] rd_cand;
   logic       wr_idx;
   logic       rd_idx;
   logic       collide;
   logic       wr_gnt;
   logic       rd_gnt;

   always_comb begin
      wr_cand = req_valid & req_write;
      rd_cand = req_valid & ~req_write;
      wr_idx  = (&wr_cand) ? wr_prio : wr_cand[1];
      rd_idx  = (&rd_cand) ? rd_prio : rd_cand[1];

      // A same-address read is held off so the BRAM read-during-write mode never matters.
      collide = (|wr_cand) && (|rd_cand) && (req_addr[rd_idx] == req_addr[wr_idx]);
      wr_gnt  = (|wr_cand) && !reset;
      rd_gnt  = (|rd_cand) && !collide && !reset;

      req_ready = 2'b00;
      if (wr_gnt) req_ready[wr_idx] = 1'b1;
      if (rd_gnt) req_ready[rd_idx] = 1'b1;

      bram_waddr    = req_addr[wr_idx];
      bram_wdata    = req_wdata[wr_idx];
      bram_write_en = wr_gnt ? req_strb[wr_idx] : '0;
      bram_raddr    = rd_gnt ? req_addr[rd_idx] : raddr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_prio      <= 1'b0;
         rd_prio      <= 1'b0;
         raddr_q      <= '0;
         resp_valid_q <= 2'b00;
      end else begin
         if (wr_gnt) wr_prio <= ~wr_idx;
         if (rd_gnt) begin
            rd_prio <= ~rd_idx;
            raddr_q <= req_addr[rd_idx];
         end
         resp_valid_q <= rd_gnt ? (2'b01 << rd_idx) : 2'b00;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = bram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// tb_bram_port_arbiter : directed scoreboard bench with a byte-enabled BRAM model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

   localparam int DW = 128;
   localparam int AW = 4;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_write;
   logic [1:0][AW-1:0] req_addr;
   logic [1:0][SW-1:0] req_strb;
   logic [1:0][DW-1:0] req_wdata;
   logic [1:0]        resp_valid;
   logic [DW-1:0]     resp_rdata;
   logic [AW-1:0]     bram_raddr;
   logic [AW-1:0]     bram_waddr;
   logic [SW-1:0]     bram_write_en;
   logic [DW-1:0]     bram_wdata;
   logic [DW-1:0]     bram_rdata;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [1:0]    owner;
      logic [DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [DW-1:0] mem [0:(1<<AW)-1];

   localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
   localparam logic [DW-1:0] D1   = {16{8'h3C}};
   localparam logic [DW-1:0] D2   = {16{8'hC3}};
   localparam logic [DW-1:0] D11  = {16{8'h11}};
   localparam logic [DW-1:0] D04  = {16{8'h04}};
   localparam logic [DW-1:0] DFF  = {16{8'hFF}};
   localparam logic [DW-1:0] DM   = {{15{8'hFF}}, 8'h00};
   localparam logic [SW-1:0] S_ALL = '1;

   always #5 clk = ~clk;

   bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .bram_raddr(bram_raddr), .bram_waddr(bram_waddr),
      .bram_write_en(bram_write_en), .bram_wdata(bram_wdata),
      .bram_rdata(bram_rdata)
   );

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = {16{8'(i)}};
   end

   // Simple-dual-port BRAM: byte-enabled write, registered read.
   always @(posedge clk) begin
      for (int b = 0; b < SW; b++)
         if (bram_write_en[b]) mem[bram_waddr][8*b +: 8] <= bram_wdata[8*b +: 8];
      bram_rdata <= mem[bram_raddr];
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Response monitor: every response must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (resp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_resp: got valid %b expected none", resp_valid);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("resp_owner", DW'(resp_valid), DW'(e.owner));
               check("resp_rdata", resp_rdata, e.data);
            end
         end
      end
   end

   task automatic drive(input string name, input logic [1:0] v, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] exp_rdy);
      @(negedge clk);
      req_valid = v;   req_write = w;
      req_addr[0] = a0; req_addr[1] = a1;
      req_strb[0] = s0; req_strb[1] = s1;
      req_wdata[0] = d0; req_wdata[1] = d1;
      #1;
      check(name, DW'(req_ready), DW'(exp_rdy));
   endtask

   task automatic push(input logic [1:0] owner, input logic [DW-1:0] data);
      exp_t e;
      e.owner = owner;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = 2'b11; req_write = 2'b11;
      req_addr = '0; req_strb = '1; req_wdata = '0;
      #3;
      check("rst_ready", DW'(req_ready), '0);
      check("rst_wen", DW'(bram_write_en), '0);
      check("rst_resp_valid", DW'(resp_valid), '0);
      check("rst_raddr", DW'(bram_raddr), '0);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b0;

      // Write then read back through the other requester.
      drive("wr3_ready", 2'b01, 2'b01, 4'd3, 4'd0, S_ALL, '0, D_A5, '0, 2'b01);
      check("wr3_wen", DW'(bram_write_en), DW'(S_ALL));
      check("wr3_waddr", DW'(bram_waddr), DW'(3));
      drive("rd3_ready", 2'b10, 2'b00, 4'd0, 4'd3, '0, '0, '0, '0, 2'b10);
      push(2'b10, D_A5);

      // Preload addr 1/2, then contend on reads for four cycles.
      drive("wr1_ready", 2'b01, 2'b01, 4'd1, 4'd0, S_ALL, '0, D1, '0, 2'b01);
      drive("wr2_ready", 2'b10, 2'b10, 4'd0, 4'd2, '0, S_ALL, '0, D2, 2'b10);
      for (int k = 0; k < 4; k++) begin
         logic [1:0] g;
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
         drive("rr_ready", 2'b11, 2'b00, 4'd1, 4'd2, '0, '0, '0, '0, g);
         push(g, (k % 2 == 0) ? D1 : D2);
      end

      // Same-address collision: write wins, read waits one cycle.
      drive("coll_ready", 2'b11, 2'b01, 4'd5, 4'd5, S_ALL, '0, D11, '0, 2'b01);
      drive("coll_rd_ready", 2'b10, 2'b00, 4'd0, 4'd5, '0, '0, '0, '0, 2'b10);
      push(2'b10, D11);

      // Concurrent read and write at different addresses.
      drive("rw_ready", 2'b11, 2'b10, 4'd4, 4'd7, '0, S_ALL, '0, D2, 2'b11);
      push(2'b01, D04);
      idle();
      #1;
      check("raddr_hold", DW'(bram_raddr), DW'(4));

      // Byte merge, then a zero-strobe write that must change nothing.
      drive("bm_full_ready", 2'b10, 2'b10, 4'd0, 4'd0, '0, S_ALL, '0, DFF, 2'b10);
      drive("bm_byte_ready", 2'b01, 2'b01, 4'd0, 4'd0, SW'(1), '0, '0, '0, 2'b01);
      drive("strb0_ready", 2'b01, 2'b01, 4'd0, 4'd0, '0, '0, '0, '0, 2'b01);
      check("strb0_wen", DW'(bram_write_en), '0);
      drive("bm_rd_ready", 2'b10, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0, 2'b10);
      push(2'b10, DM);
      idle();

      // Reset while a response is in flight drops it and restores r0 priority.
      drive("rstmid_ready", 2'b01, 2'b00, 4'd1, 4'd0, '0, '0, '0, '0, 2'b01);
      @(posedge clk);
      #2;
      reset = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      check("rstmid_resp_valid", DW'(resp_valid), '0);
      reset = 1'b0;
      drive("post_rst_ready", 2'b11, 2'b00, 4'd1, 4'd2, '0, '0, '0, '0, 2'b01);
      push(2'b01, D1);
      idle();

      repeat (4) @(negedge clk);
      check("queue_empty", DW'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
